// File: rtl/ps2_pkg.sv
// Shared frame-FSM encoding, prefix constants and key-event payload for the PS/2 receiver.
package ps2_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } key_evt_t;

  // Odd parity across data+parity and a high stop bit make a frame acceptable.
  function automatic logic frame_ok(input logic [7:0] data, input logic par, input logic stop);
    return (^{data, par}) & stop;
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchronizers for the raw PS/2 lines plus a run-length debounce of the clock line.
module ps2_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic fall_o,
  output logic data_o
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]       clk_sync_q;
  logic [1:0]       data_sync_q;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fall_q, fall_d;

  // Level flips once the opposite level has been seen FILTER_LEN cycles in a row.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    fall_d = filt_q & ~filt_d;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      cnt_q       <= '0;
      fall_q      <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      fall_q      <= fall_d;
    end
  end

  assign fall_o = fall_q;
  assign data_o = data_sync_q[1];

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: frame FSM with timeout, byte checks and E0/F0 prefix tracking.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       frame_err
);

  localparam int unsigned   TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic fall, sdata;

  frame_state_e state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            ext_q, ext_d;
  logic            brk_q, brk_d;
  logic            byte_valid_q, byte_valid_d;
  logic [7:0]      byte_data_q, byte_data_d;
  logic            key_valid_q, key_valid_d;
  key_evt_t        key_q, key_d;
  logic            frame_err_q, frame_err_d;

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk        (clk),
    .clr        (clr),
    .ps2_clk_i  (ps2_clk),
    .ps2_data_i (ps2_data),
    .fall_o     (fall),
    .data_o     (sdata)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    to_cnt_d     = '0;
    ext_d        = ext_q;
    brk_d        = brk_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    key_valid_d  = 1'b0;
    key_d        = key_q;
    frame_err_d  = 1'b0;

    if (!fall && state_q != ST_IDLE) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    // A falling edge wins over a timeout landing in the same cycle.
    if (fall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (sdata) begin
            frame_err_d = 1'b1;
          end else begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {sdata, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = sdata;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (frame_ok(shift_q, par_q, sdata)) begin
            byte_valid_d = 1'b1;
            byte_data_d  = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && to_cnt_q == TO_LAST) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = '0;
      shift_d     = '0;
      to_cnt_d    = '0;
      frame_err_d = 1'b1;
    end

    // Prefix tracker consumes the byte reported in the previous cycle.
    if (byte_valid_q) begin
      if (byte_data_q == PREFIX_EXT) begin
        ext_d = 1'b1;
      end else if (byte_data_q == PREFIX_BRK) begin
        brk_d = 1'b1;
      end else begin
        key_valid_d = 1'b1;
        key_d       = '{code: byte_data_q, ext: ext_q, brk: brk_q};
        ext_d       = 1'b0;
        brk_d       = 1'b0;
      end
    end

    if (frame_err_d) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      key_valid_q  <= 1'b0;
      key_q        <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      key_valid_q  <= key_valid_d;
      key_q        <= key_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign key_valid  = key_valid_q;
  assign key_code   = key_q.code;
  assign key_ext    = key_q.ext;
  assign key_break  = key_q.brk;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: directed and randomized PS/2 frames against a queue-based model.
module tb_ps2_scancode_rx;

  localparam int unsigned FILT = 4;
  localparam int unsigned TMO  = 500;
  localparam int unsigned HALF = 20;
  localparam logic [7:0]  EXT  = 8'hE0;
  localparam logic [7:0]  BRK  = 8'hF0;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } key_t;

  logic       clk      = 1'b0;
  logic       clr      = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       frame_err;

  ps2_scancode_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .clr        (clr),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_break  (key_break),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned vectors = 0, miscompares = 0;
  int unsigned bytes_seen = 0, keys_seen = 0, errs_seen = 0;

  // Model: expected pulses in order, each with the earliest cycle it may appear.
  logic [7:0]  exp_byte_q[$];
  int unsigned exp_byte_lo[$];
  key_t        exp_key_q[$];
  int unsigned exp_err_lo[$];
  bit          m_ext = 1'b0, m_brk = 1'b0;
  logic [7:0]  m_last_byte = 8'h00;
  key_t        m_last_key = '0;
  bit          prev_bv = 1'b0;
  logic [7:0]  prev_b = 8'h00;
  int unsigned last_fall = 0;
  bit          glitch_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_win(input string name, input int unsigned at, input int unsigned lo);
    vectors++;
    if (at < lo || at > lo + 2) begin
      miscompares++;
      $display("FAIL %s: pulse at cycle %0d, required %0d..%0d", name, at, lo, lo + 2);
    end
  endtask

  task automatic model_good(input logic [7:0] b);
    exp_byte_q.push_back(b);
    exp_byte_lo.push_back(last_fall + FILT + 2);
    if (b == EXT) m_ext = 1'b1;
    else if (b == BRK) m_brk = 1'b1;
    else begin
      exp_key_q.push_back('{code: b, ext: m_ext, brk: m_brk});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_err(input int unsigned lo);
    exp_err_lo.push_back(lo);
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // High phase (optionally with a 2-cycle low glitch), then the real falling edge.
  task automatic drive_fall(input logic b);
    ps2_data = b;
    if (glitch_en && $urandom_range(0, 9) == 0) begin
      tick(5);
      ps2_clk = 1'b0;
      tick(2);
      ps2_clk = 1'b1;
      tick(HALF - 7);
    end else begin
      tick(HALF);
    end
    ps2_clk   = 1'b0;
    last_fall = cyc;
  endtask

  task automatic drive_rise();
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      drive_fall(bits[i]);
      if (i == 10) begin
        if (!bad_par && !bad_stop) model_good(b);
        else model_err(last_fall + FILT + 2);
      end
      drive_rise();
    end
    ps2_data = 1'b1;
    tick(30);
  endtask

  task automatic send_partial(input int unsigned nbits);
    drive_fall(1'b0);
    drive_rise();
    for (int i = 0; i < int'(nbits); i++) begin
      drive_fall(1'($urandom_range(0, 1)));
      drive_rise();
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_timeout(input int unsigned nbits);
    send_partial(nbits);
    model_err(last_fall + TMO + FILT + 2);
    tick(TMO + 40);
  endtask

  task automatic send_start_err();
    drive_fall(1'b1);
    model_err(last_fall + FILT + 2);
    drive_rise();
    tick(30);
  endtask

  // Single compare process: every cycle the outputs are checked against the model.
  always @(negedge clk) begin
    if (!clr) begin
      check("reset_outputs", 32'({byte_valid, byte_data, key_valid, key_code, key_ext, key_break, frame_err}), 32'h0);
      m_last_byte = 8'h00;
      m_last_key  = '0;
      prev_bv     = 1'b0;
      prev_b      = 8'h00;
    end else begin
      if (byte_valid) begin
        bytes_seen++;
        if (exp_byte_q.size() == 0) check("byte_valid_spurious", 32'(byte_valid), 32'h0);
        else begin
          m_last_byte = exp_byte_q.pop_front();
          check_win("byte_latency", cyc, exp_byte_lo.pop_front());
        end
      end
      check("byte_data", 32'(byte_data), 32'(m_last_byte));
      if (key_valid) begin
        keys_seen++;
        check("key_one_after_byte", 32'(prev_bv), 32'h1);
        if (exp_key_q.size() == 0) check("key_valid_spurious", 32'(key_valid), 32'h0);
        else m_last_key = exp_key_q.pop_front();
      end else if (prev_bv && prev_b != EXT && prev_b != BRK) begin
        check("key_valid_missing", 32'(key_valid), 32'h1);
      end
      check("key_fields", 32'({key_code, key_ext, key_break}), 32'(m_last_key));
      if (frame_err) begin
        errs_seen++;
        if (exp_err_lo.size() == 0) check("frame_err_spurious", 32'(frame_err), 32'h0);
        else check_win("frame_err_latency", cyc, exp_err_lo.pop_front());
      end
      prev_bv = byte_valid;
      prev_b  = m_last_byte;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned k0, e0, b0;
    logic [7:0]  b;
    int unsigned r;

    tick(5);
    clr = 1'b1;
    tick(10);

    // Plain make code
    send_frame(8'h1C, 1'b0, 1'b0);
    check("pin_1c_byte", 32'(byte_data), 32'h1C);
    check("pin_1c_key", 32'({key_code, key_ext, key_break}), 32'({8'h1C, 1'b0, 1'b0}));
    check("pin_1c_keycount", keys_seen, 1);

    // Extended break sequence
    k0 = keys_seen;
    send_frame(8'hE0, 1'b0, 1'b0);
    check("pin_no_key_after_e0", keys_seen, k0);
    send_frame(8'hF0, 1'b0, 1'b0);
    check("pin_no_key_after_f0", keys_seen, k0);
    send_frame(8'h75, 1'b0, 1'b0);
    check("pin_75_key", 32'({key_code, key_ext, key_break}), 32'({8'h75, 1'b1, 1'b1}));
    check("pin_75_keycount", keys_seen, k0 + 1);
    send_frame(8'h16, 1'b0, 1'b0);
    check("pin_16_key", 32'({key_code, key_ext, key_break}), 32'({8'h16, 1'b0, 1'b0}));

    // Bad parity leaves byte_data alone
    b0 = bytes_seen;
    e0 = errs_seen;
    send_frame(8'h1C, 1'b1, 1'b0);
    check("pin_badpar_byte", 32'(byte_data), 32'h16);
    check("pin_badpar_err", errs_seen, e0 + 1);
    check("pin_badpar_nobyte", bytes_seen, b0);

    send_frame(8'hA5, 1'b0, 1'b1);
    send_start_err();

    // Break prefix, then a stalled frame: the timeout must drop the prefix
    send_frame(8'hF0, 1'b0, 1'b0);
    e0 = errs_seen;
    send_timeout(4);
    check("pin_timeout_err", errs_seen, e0 + 1);
    send_frame(8'h12, 1'b0, 1'b0);
    check("pin_12_key", 32'({key_code, key_ext, key_break}), 32'({8'h12, 1'b0, 1'b0}));

    // Short low glitch on an idle line
    b0 = bytes_seen;
    e0 = errs_seen;
    ps2_clk = 1'b0;
    tick(2);
    ps2_clk = 1'b1;
    tick(40);
    check("pin_glitch_nobyte", bytes_seen, b0);
    check("pin_glitch_noerr", errs_seen, e0);
    check("pin_glitch_byte", 32'(byte_data), 32'h12);

    // Reset after the 5th data bit, then a clean frame
    send_partial(5);
    tick(5);
    @(posedge clk);
    #1 clr = 1'b0;
    m_ext = 1'b0;
    m_brk = 1'b0;
    tick(10);
    @(posedge clk);
    #1 clr = 1'b1;
    tick(20);
    b0 = bytes_seen;
    e0 = errs_seen;
    send_frame(8'h29, 1'b0, 1'b0);
    check("pin_29_byte", 32'(byte_data), 32'h29);
    check("pin_29_key", 32'({key_code, key_ext, key_break}), 32'({8'h29, 1'b0, 1'b0}));
    check("pin_29_onebyte", bytes_seen, b0 + 1);
    check("pin_29_noerr", errs_seen, e0);

    // Randomized traffic with glitches, prefixes, bad frames and stalls
    glitch_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 99);
      if (r < 5) begin
        send_timeout($urandom_range(1, 7));
      end else if (r < 9) begin
        send_start_err();
      end else begin
        case ($urandom_range(0, 9))
          0: b = EXT;
          1: b = BRK;
          2: b = 8'hE1;
          3: b = 8'hAA;
          4: b = 8'hFA;
          default: b = 8'($urandom_range(0, 255));
        endcase
        send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
      end
    end

    tick(50);
    check("pending_bytes", exp_byte_q.size(), 0);
    check("pending_keys", exp_key_q.size(), 0);
    check("pending_errs", exp_err_lo.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
